// File: rtl/system_partition_bank_pkg.sv
// Shared parameters for the partition register bank.
//   SINGLE     : default channel data width (single-precision word)
//   STEP_W_DEF : default step counter width
//   clog2()    : constant function for the derived address width
package system_partition_bank_pkg;

  localparam int unsigned SINGLE     = 32;
  localparam int unsigned STEP_W_DEF = 16;

  // Minimum bit count able to index n entries (at least 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << r) < n) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/system_partition_bank_if.sv
// Bus interface of the partition register bank.
// master : producer/consumer side (drives writes, commit, reads)
// slave  : bank side
//   control_valuation_sig  commit strobe, shadow -> active
//   wr_en/wr_addr/wr_data  shadow write port
//   rd_addr/rd_data        registered active-bank read port
//   cout                   flattened active bank, channel k at [k*WIDTH +: WIDTH]
//   all_written            every channel written since last commit
//   step_cnt               commits since reset
//   err_incomplete/err_addr sticky errors, err_clr clears both
interface system_partition_bank_if #(
  parameter int unsigned WIDTH  = system_partition_bank_pkg::SINGLE,
  parameter int unsigned N_CH   = 8,
  parameter int unsigned STEP_W = system_partition_bank_pkg::STEP_W_DEF
);
  localparam int unsigned CH_W = system_partition_bank_pkg::clog2(N_CH);

  logic                    control_valuation_sig;
  logic                    wr_en;
  logic [CH_W-1:0]         wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic [CH_W-1:0]         rd_addr;
  logic [WIDTH-1:0]        rd_data;
  logic [N_CH*WIDTH-1:0]   cout;
  logic                    all_written;
  logic [STEP_W-1:0]       step_cnt;
  logic                    err_incomplete;
  logic                    err_addr;
  logic                    err_clr;

  modport master (
    output control_valuation_sig, wr_en, wr_addr, wr_data, rd_addr, err_clr,
    input  rd_data, cout, all_written, step_cnt, err_incomplete, err_addr
  );

  modport slave (
    input  control_valuation_sig, wr_en, wr_addr, wr_data, rd_addr, err_clr,
    output rd_data, cout, all_written, step_cnt, err_incomplete, err_addr
  );

endinterface

// File: rtl/system_partition_bank_channel_reg.sv
// partition_channel_reg: one shadow/active register pair.
//   clk, rst    clock, synchronous active-high reset
//   i_wr        write this channel's shadow
//   i_wr_data   write data
//   i_commit    copy shadow into active
//   o_active    active value
// PARTITION_BYPASS_EN: a write coincident with a commit is forwarded
// straight into active in that same commit.
module partition_channel_reg #(
  parameter int unsigned WIDTH = system_partition_bank_pkg::SINGLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_commit,
  output logic [WIDTH-1:0] o_active
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] w_commit_val;

`ifdef PARTITION_BYPASS_EN
  assign w_commit_val = i_wr ? i_wr_data : r_shadow;
`else
  // Commit snapshots the shadow before a same-cycle write lands.
  assign w_commit_val = r_shadow;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (i_wr)     r_shadow <= i_wr_data;
      if (i_commit) r_active <= w_commit_val;
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/system_partition_bank.sv
// Double-buffered multi-channel interface register bank between solvers.
// Producer fills the shadow bank during a step; the commit strobe moves
// every channel to the active bank on the same edge.
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  system_partition_bank_if.slave (writes, commit, read, status)
// Optional macro PARTITION_BYPASS_EN: forward a write coincident with a
// commit into the active bank in that same commit.
module system_partition_bank #(
  parameter int unsigned WIDTH  = system_partition_bank_pkg::SINGLE,
  parameter int unsigned N_CH   = 8,
  parameter int unsigned STEP_W = system_partition_bank_pkg::STEP_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  system_partition_bank_if.slave bus
);
  import system_partition_bank_pkg::*;

  localparam int unsigned CH_W = clog2(N_CH);

  logic [N_CH-1:0]   r_written;
  logic [N_CH-1:0]   w_written_nxt;
  logic [N_CH-1:0]   w_wr_sel;
  logic [WIDTH-1:0]  w_active [N_CH];
  logic [WIDTH-1:0]  r_rd_data;
  logic [STEP_W-1:0] r_step_cnt;
  logic              r_err_incomplete;
  logic              r_err_addr;
  logic              w_commit;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_all_written;
  logic              w_all_written_eff;
  logic              w_addr_evt;
  logic              w_inc_evt;

  assign w_commit = bus.control_valuation_sig;
  // One extra bit keeps the range check meaningful for power-of-two N_CH.
  assign w_wr_ok  = ({1'b0, bus.wr_addr} < (CH_W+1)'(N_CH));
  assign w_rd_ok  = ({1'b0, bus.rd_addr} < (CH_W+1)'(N_CH));

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_wr_sel[k] = bus.wr_en & w_wr_ok & (bus.wr_addr == CH_W'(k));

    partition_channel_reg #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (w_wr_sel[k]),
      .i_wr_data (bus.wr_data),
      .i_commit  (w_commit),
      .o_active  (w_active[k])
    );

    assign bus.cout[k*WIDTH +: WIDTH] = w_active[k];
  end

  assign w_all_written = &r_written;

`ifdef PARTITION_BYPASS_EN
  // Forwarded write is part of this commit, so it counts now and not later.
  assign w_all_written_eff = &(r_written | w_wr_sel);
  always_comb begin
    w_written_nxt = r_written | w_wr_sel;
    if (w_commit) w_written_nxt = '0;
  end
`else
  // Coincident write is set after the clear: it belongs to the next step.
  assign w_all_written_eff = w_all_written;
  always_comb begin
    w_written_nxt = r_written;
    if (w_commit) w_written_nxt = '0;
    w_written_nxt = w_written_nxt | w_wr_sel;
  end
`endif

  assign w_addr_evt = (bus.wr_en & ~w_wr_ok) | ~w_rd_ok;
  assign w_inc_evt  = w_commit & ~w_all_written_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_written        <= '0;
      r_rd_data        <= '0;
      r_step_cnt       <= '0;
      r_err_incomplete <= 1'b0;
      r_err_addr       <= 1'b0;
    end else begin
      r_written <= w_written_nxt;
      r_rd_data <= w_rd_ok ? w_active[bus.rd_addr] : '0;
      if (w_commit) r_step_cnt <= r_step_cnt + 1'b1;

      // A new error event outranks a same-cycle clear.
      if (w_inc_evt)        r_err_incomplete <= 1'b1;
      else if (bus.err_clr) r_err_incomplete <= 1'b0;

      if (w_addr_evt)       r_err_addr <= 1'b1;
      else if (bus.err_clr) r_err_addr <= 1'b0;
    end
  end

  assign bus.rd_data        = r_rd_data;
  assign bus.all_written    = w_all_written;
  assign bus.step_cnt       = r_step_cnt;
  assign bus.err_incomplete = r_err_incomplete;
  assign bus.err_addr       = r_err_addr;

endmodule

// File: tb/tb_system_partition_bank.sv
module tb_system_partition_bank;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A: default 8 channels; B: 6 channels (out-of-range addresses); C: 4-bit counter
  system_partition_bank_if #(.WIDTH(32), .N_CH(8), .STEP_W(16)) a_if ();
  system_partition_bank_if #(.WIDTH(32), .N_CH(6), .STEP_W(16)) b_if ();
  system_partition_bank_if #(.WIDTH(32), .N_CH(8), .STEP_W(4))  c_if ();

  system_partition_bank #(.WIDTH(32), .N_CH(8), .STEP_W(16)) u_a (
    .clk(clk), .rst(rst), .bus(a_if.slave));
  system_partition_bank #(.WIDTH(32), .N_CH(6), .STEP_W(16)) u_b (
    .clk(clk), .rst(rst), .bus(b_if.slave));
  system_partition_bank #(.WIDTH(32), .N_CH(8), .STEP_W(4)) u_c (
    .clk(clk), .rst(rst), .bus(c_if.slave));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic a_write(input int ch, input logic [31:0] d);
    a_if.wr_en = 1'b1; a_if.wr_addr = 3'(ch); a_if.wr_data = d;
    tick();
    a_if.wr_en = 1'b0;
  endtask

  task automatic a_strobe();
    a_if.control_valuation_sig = 1'b1;
    tick();
    a_if.control_valuation_sig = 1'b0;
  endtask

  task automatic a_errclr();
    a_if.err_clr = 1'b1;
    tick();
    a_if.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    a_write(1, $urandom); a_write(6, $urandom);
    a_strobe();
    c_if.wr_en = 1'b1; c_if.wr_addr = 3'd4; c_if.wr_data = $urandom;
    b_if.wr_en = 1'b1; b_if.wr_addr = 3'd7; b_if.wr_data = $urandom;
    tick();
    c_if.wr_en = 1'b0; b_if.wr_en = 1'b0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (a_if.cout !== '0) begin errors++; $display("FAIL reset_cout got=%h exp=0", a_if.cout); end
    checks++; if (a_if.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", a_if.rd_data); end
    checks++; if (a_if.step_cnt !== 16'd0) begin errors++; $display("FAIL reset_step got=%0d exp=0", a_if.step_cnt); end
    checks++; if (a_if.err_incomplete !== 1'b0) begin errors++; $display("FAIL reset_err_inc got=%b exp=0", a_if.err_incomplete); end
    checks++; if (a_if.err_addr !== 1'b0) begin errors++; $display("FAIL reset_err_addr got=%b exp=0", a_if.err_addr); end
    checks++; if (a_if.all_written !== 1'b0) begin errors++; $display("FAIL reset_all_written got=%b exp=0", a_if.all_written); end
    checks++; if (b_if.err_addr !== 1'b0) begin errors++; $display("FAIL reset_b_err_addr got=%b exp=0", b_if.err_addr); end
    checks++; if (c_if.cout !== '0) begin errors++; $display("FAIL reset_c_cout got=%h exp=0", c_if.cout); end
  endtask

  task automatic test_full_step();
    for (int k = 0; k < 8; k++) a_write(k, 32'h3F80_0000 + 32'(k));
    checks++; if (a_if.all_written !== 1'b1) begin errors++; $display("FAIL full_all_written_pre got=%b exp=1", a_if.all_written); end
    a_strobe();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a_if.cout[k*32 +: 32] !== 32'h3F80_0000 + 32'(k)) begin
        errors++; $display("FAIL full_cout_ch%0d got=%h exp=%h", k, a_if.cout[k*32 +: 32], 32'h3F80_0000 + 32'(k));
      end
    end
    checks++; if (a_if.step_cnt !== 16'd1) begin errors++; $display("FAIL full_step got=%0d exp=1", a_if.step_cnt); end
    checks++; if (a_if.err_incomplete !== 1'b0) begin errors++; $display("FAIL full_err_inc got=%b exp=0", a_if.err_incomplete); end
    checks++; if (a_if.all_written !== 1'b0) begin errors++; $display("FAIL full_all_written_post got=%b exp=0", a_if.all_written); end
  endtask

  task automatic test_partial_step();
    logic [31:0] exp;
    a_write(2, 32'h4000_0000);
    a_strobe();
    for (int k = 0; k < 8; k++) begin
      exp = (k == 2) ? 32'h4000_0000 : 32'h3F80_0000 + 32'(k);
      checks++;
      if (a_if.cout[k*32 +: 32] !== exp) begin
        errors++; $display("FAIL partial_cout_ch%0d got=%h exp=%h", k, a_if.cout[k*32 +: 32], exp);
      end
    end
    checks++; if (a_if.err_incomplete !== 1'b1) begin errors++; $display("FAIL partial_err_inc got=%b exp=1", a_if.err_incomplete); end
    checks++; if (a_if.step_cnt !== 16'd2) begin errors++; $display("FAIL partial_step got=%0d exp=2", a_if.step_cnt); end
    a_errclr();
    checks++; if (a_if.err_incomplete !== 1'b0) begin errors++; $display("FAIL partial_err_clr got=%b exp=0", a_if.err_incomplete); end
  endtask

  task automatic test_coincident();
    logic [31:0] exp5;
`ifdef PARTITION_BYPASS_EN
    exp5 = 32'hDEAD_BEEF;
`else
    exp5 = 32'h3F80_0005;
`endif
    a_if.wr_en = 1'b1; a_if.wr_addr = 3'd5; a_if.wr_data = 32'hDEAD_BEEF;
    a_if.control_valuation_sig = 1'b1;
    tick();
    a_if.wr_en = 1'b0; a_if.control_valuation_sig = 1'b0;
    checks++; if (a_if.cout[5*32 +: 32] !== exp5) begin errors++; $display("FAIL coinc_ch5_first got=%h exp=%h", a_if.cout[5*32 +: 32], exp5); end
    checks++; if (a_if.cout[2*32 +: 32] !== 32'h4000_0000) begin errors++; $display("FAIL coinc_ch2_hold got=%h exp=40000000", a_if.cout[2*32 +: 32]); end
    checks++; if (a_if.step_cnt !== 16'd3) begin errors++; $display("FAIL coinc_step got=%0d exp=3", a_if.step_cnt); end
    checks++; if (a_if.all_written !== 1'b0) begin errors++; $display("FAIL coinc_all_written got=%b exp=0", a_if.all_written); end
    a_strobe();
    checks++; if (a_if.cout[5*32 +: 32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL coinc_ch5_second got=%h exp=deadbeef", a_if.cout[5*32 +: 32]); end
    checks++; if (a_if.step_cnt !== 16'd4) begin errors++; $display("FAIL coinc_step2 got=%0d exp=4", a_if.step_cnt); end
    a_errclr();
  endtask

  task automatic test_read();
    a_write(3, 32'h1234_5678);
    a_if.rd_addr = 3'd3;
    a_strobe();
    checks++; if (a_if.rd_data !== 32'h3F80_0003) begin errors++; $display("FAIL read_commit_cycle got=%h exp=3f800003", a_if.rd_data); end
    checks++; if (a_if.cout[3*32 +: 32] !== 32'h1234_5678) begin errors++; $display("FAIL read_cout_ch3 got=%h exp=12345678", a_if.cout[3*32 +: 32]); end
    tick();
    checks++; if (a_if.rd_data !== 32'h1234_5678) begin errors++; $display("FAIL read_next got=%h exp=12345678", a_if.rd_data); end
    checks++; if (a_if.step_cnt !== 16'd5) begin errors++; $display("FAIL read_step got=%0d exp=5", a_if.step_cnt); end
    a_if.rd_addr = 3'd0;
  endtask

  task automatic test_back_to_back();
    a_errclr();
    for (int k = 0; k < 8; k++) a_write(k, 32'h4100_0000 + 32'(k));
    a_if.control_valuation_sig = 1'b1;
    tick();
    checks++; if (a_if.err_incomplete !== 1'b0) begin errors++; $display("FAIL b2b_first_err_inc got=%b exp=0", a_if.err_incomplete); end
    checks++; if (a_if.cout[7*32 +: 32] !== 32'h4100_0007) begin errors++; $display("FAIL b2b_ch7 got=%h exp=41000007", a_if.cout[7*32 +: 32]); end
    tick();
    a_if.control_valuation_sig = 1'b0;
    checks++; if (a_if.err_incomplete !== 1'b1) begin errors++; $display("FAIL b2b_second_err_inc got=%b exp=1", a_if.err_incomplete); end
    checks++; if (a_if.step_cnt !== 16'd7) begin errors++; $display("FAIL b2b_step got=%0d exp=7", a_if.step_cnt); end
  endtask

  task automatic test_addr_err();
    b_if.wr_en = 1'b1; b_if.wr_addr = 3'd1; b_if.wr_data = 32'h0000_0011;
    tick();
    b_if.wr_en = 1'b0; b_if.rd_addr = 3'd1; b_if.control_valuation_sig = 1'b1;
    tick();
    b_if.control_valuation_sig = 1'b0;
    checks++; if (b_if.cout[1*32 +: 32] !== 32'h11) begin errors++; $display("FAIL addr_b_ch1 got=%h exp=11", b_if.cout[1*32 +: 32]); end
    tick();
    checks++; if (b_if.rd_data !== 32'h11) begin errors++; $display("FAIL addr_b_rd1 got=%h exp=11", b_if.rd_data); end
    checks++; if (b_if.err_addr !== 1'b0) begin errors++; $display("FAIL addr_b_no_err got=%b exp=0", b_if.err_addr); end
    b_if.wr_en = 1'b1; b_if.wr_addr = 3'd7; b_if.wr_data = 32'hFFFF_FFFF;
    tick();
    b_if.wr_en = 1'b0;
    checks++; if (b_if.err_addr !== 1'b1) begin errors++; $display("FAIL addr_b_wr7_err got=%b exp=1", b_if.err_addr); end
    b_if.control_valuation_sig = 1'b1;
    tick();
    b_if.control_valuation_sig = 1'b0;
    checks++; if (b_if.cout !== 192'h11 << 32) begin errors++; $display("FAIL addr_b_cout got=%h exp=%h", b_if.cout, 192'h11 << 32); end
    b_if.err_clr = 1'b1; tick(); b_if.err_clr = 1'b0;
    checks++; if (b_if.err_addr !== 1'b0) begin errors++; $display("FAIL addr_b_clr got=%b exp=0", b_if.err_addr); end
    b_if.rd_addr = 3'd6;
    tick();
    checks++; if (b_if.rd_data !== 32'h0) begin errors++; $display("FAIL addr_b_rd6 got=%h exp=0", b_if.rd_data); end
    checks++; if (b_if.err_addr !== 1'b1) begin errors++; $display("FAIL addr_b_rd6_err got=%b exp=1", b_if.err_addr); end
    b_if.err_clr = 1'b1;
    tick();
    checks++; if (b_if.err_addr !== 1'b1) begin errors++; $display("FAIL addr_b_clr_vs_evt got=%b exp=1", b_if.err_addr); end
    b_if.rd_addr = 3'd0;
    tick();
    b_if.err_clr = 1'b0;
    checks++; if (b_if.err_addr !== 1'b0) begin errors++; $display("FAIL addr_b_clr2 got=%b exp=0", b_if.err_addr); end
  endtask

  task automatic test_wrap();
    c_if.control_valuation_sig = 1'b1;
    repeat (15) tick();
    checks++; if (c_if.step_cnt !== 4'd15) begin errors++; $display("FAIL wrap_15 got=%0d exp=15", c_if.step_cnt); end
    tick();
    checks++; if (c_if.step_cnt !== 4'd0) begin errors++; $display("FAIL wrap_0 got=%0d exp=0", c_if.step_cnt); end
    tick();
    c_if.control_valuation_sig = 1'b0;
    checks++; if (c_if.step_cnt !== 4'd1) begin errors++; $display("FAIL wrap_1 got=%0d exp=1", c_if.step_cnt); end
    checks++; if (c_if.err_incomplete !== 1'b1) begin errors++; $display("FAIL wrap_err_inc got=%b exp=1", c_if.err_incomplete); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    a_if.control_valuation_sig = 1'b0; a_if.wr_en = 1'b0; a_if.wr_addr = '0;
    a_if.wr_data = '0; a_if.rd_addr = '0; a_if.err_clr = 1'b0;
    b_if.control_valuation_sig = 1'b0; b_if.wr_en = 1'b0; b_if.wr_addr = '0;
    b_if.wr_data = '0; b_if.rd_addr = '0; b_if.err_clr = 1'b0;
    c_if.control_valuation_sig = 1'b0; c_if.wr_en = 1'b0; c_if.wr_addr = '0;
    c_if.wr_data = '0; c_if.rd_addr = '0; c_if.err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    test_reset();
    test_full_step();
    test_partial_step();
    test_coincident();
    test_read();
    test_back_to_back();
    test_addr_err();
    test_wrap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
